// File: rtl/dpram_port_sched_pkg.sv
// -----------------------------------------------------------------------------
// dpram_sched_pkg
// Shared types and constants for the dual-port RAM write-port scheduler.
//   state_t : scheduler FSM states
//   GNT_A   : grant id of requester A (CPU side)
//   GNT_B   : grant id of requester B (loader/debug side)
//   other_gnt() : the opposite grant id, used by the round-robin pick
// -----------------------------------------------------------------------------
package dpram_sched_pkg;

   // CLEAR : sweeping the fill value across the whole RAM
   // IDLE  : accepting clear requests and arbitrating accesses
   // ISSUE : RAM performs the granted access at the end of this cycle
   // WAIT  : registered doutb is valid, capture it and acknowledge
   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } state_t;

   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

   function automatic logic other_gnt(input logic gnt);
      return (gnt == GNT_A) ? GNT_B : GNT_A;
   endfunction

endpackage : dpram_sched_pkg

// File: rtl/dpram_port_sched_if.sv
// -----------------------------------------------------------------------------
// dpram_port_sched_if
// Bundles every non-clock signal around the scheduler: the clear handshake,
// the two requester ports and the RAM write/readback port.
//   clear_req/clear_done         : clear request pulse / no clear running
//   a_req,a_we,a_addr,a_wdata     : requester A access (held until a_ack)
//   a_ack,a_rdata                 : A completion pulse and pre-access data
//   b_*                           : same set for requester B
//   mem_we,mem_waddr,mem_wdata    : to the RAM write port
//   mem_doutb                     : from the RAM, one-cycle registered read
// Modports:
//   slave  : the scheduler itself
//   master : the environment (requesters plus the RAM)
// -----------------------------------------------------------------------------
interface dpram_port_sched_if #(
   parameter int AW = 10,
   parameter int DW = 8
);
   logic          clear_req;
   logic          clear_done;

   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_ack;
   logic [DW-1:0] a_rdata;

   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_ack;
   logic [DW-1:0] b_rdata;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_doutb;

   modport slave (
      input  clear_req,
      output clear_done,
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata,
      output mem_we, mem_waddr, mem_wdata,
      input  mem_doutb
   );

   modport master (
      output clear_req,
      input  clear_done,
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  mem_we, mem_waddr, mem_wdata,
      output mem_doutb
   );

endinterface : dpram_port_sched_if

// File: rtl/dpram_rr_arb2.sv
// -----------------------------------------------------------------------------
// dpram_rr_arb2
// Combinational two-way round-robin pick.
//   i_a_req      : requester A wants the port
//   i_b_req      : requester B wants the port
//   i_last_grant : id of the most recent grant (GNT_A / GNT_B)
//   o_winner     : id of the requester to serve
//   o_valid      : at least one requester is asking
// When both ask, the one that was not served last wins; a lone requester
// wins regardless of history.
// -----------------------------------------------------------------------------
module dpram_rr_arb2
   import dpram_sched_pkg::*;
(
   input  logic i_a_req,
   input  logic i_b_req,
   input  logic i_last_grant,
   output logic o_winner,
   output logic o_valid
);

   always_comb begin
      // NOTE: every output gets a default before any branch so no path
      // leaves it unassigned and no latch is inferred.
      o_valid  = i_a_req | i_b_req;
      o_winner = GNT_A;
      if (i_a_req && i_b_req) begin
         o_winner = other_gnt(i_last_grant);
      end else if (i_b_req) begin
         o_winner = GNT_B;
      end
   end

endmodule : dpram_rr_arb2

// File: rtl/dpram_port_sched.sv
// -----------------------------------------------------------------------------
// dpram_port_sched
// Owns the registered write/readback port of a dual-port video/work RAM and
// shares it between requester A (CPU) and requester B (loader/debug). After
// reset, and whenever a clear is requested, it writes FILL to every location
// before serving any access. The RAM's read-only scan-out port is untouched.
//
// Parameters:
//   AW   : RAM address width (depth 2^AW)
//   DW   : data width
//   FILL : value written to every location during a clear
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dpram_port_sched_if.slave (clear handshake, A/B ports, RAM port)
//
// Access timing, request sampled in IDLE at cycle T:
//   T+1 ISSUE : mem_we/waddr/wdata visible, RAM acts at the end of the cycle
//   T+2 WAIT  : mem_doutb holds the pre-access contents
//   T+3 IDLE  : ack pulse with rdata; a request still high here is new
// -----------------------------------------------------------------------------
module dpram_port_sched
   import dpram_sched_pkg::*;
#(
   parameter int            AW   = 10,
   parameter int            DW   = 8,
   parameter logic [DW-1:0] FILL = '0
) (
   input  logic               clk,
   input  logic               reset,
   dpram_port_sched_if.slave  bus
);

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   state_t        r_state;
   logic [AW-1:0] r_cnt;            // clear sweep address, wraps to 0 at the end
   logic          r_last_grant;
   logic          r_gnt;            // id of the access in flight
   logic          r_clear_pending;  // clear requested while an access was in flight
   logic          r_clear_done;

   logic          r_mem_we;
   logic [AW-1:0] r_mem_waddr;
   logic [DW-1:0] r_mem_wdata;

   logic          r_a_ack;
   logic [DW-1:0] r_a_rdata;
   logic          r_b_ack;
   logic [DW-1:0] r_b_rdata;

   // ---------------------------------------------------------------------------
   // Arbitration and winner field select
   // ---------------------------------------------------------------------------
   logic          w_winner;
   logic          w_valid;
   logic          w_win_we;
   logic [AW-1:0] w_win_addr;
   logic [DW-1:0] w_win_wdata;

   dpram_rr_arb2 u_arb (
      .i_a_req      (bus.a_req),
      .i_b_req      (bus.b_req),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner),
      .o_valid      (w_valid)
   );

   assign w_win_we    = (w_winner == GNT_A) ? bus.a_we    : bus.b_we;
   assign w_win_addr  = (w_winner == GNT_A) ? bus.a_addr  : bus.b_addr;
   assign w_win_wdata = (w_winner == GNT_A) ? bus.a_wdata : bus.b_wdata;

   // ---------------------------------------------------------------------------
   // Scheduler FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= CLEAR;
         r_cnt           <= '0;
         r_last_grant    <= GNT_B;
         r_gnt           <= GNT_A;
         r_clear_pending <= 1'b0;
         r_clear_done    <= 1'b0;
         r_mem_we        <= 1'b0;
         r_mem_waddr     <= '0;
         r_mem_wdata     <= '0;
         r_a_ack         <= 1'b0;
         r_a_rdata       <= '0;
         r_b_ack         <= 1'b0;
         r_b_rdata       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register here samples values from before this clock edge.
         // Acks are single-cycle pulses; only WAIT raises one.
         r_a_ack <= 1'b0;
         r_b_ack <= 1'b0;

         case (r_state)
            CLEAR: begin
               // One write per cycle with no gaps; clear_req is ignored here.
               r_mem_we    <= 1'b1;
               r_mem_waddr <= r_cnt;
               r_mem_wdata <= FILL;
               r_cnt       <= r_cnt + AW'(1);
               if (&r_cnt) begin
                  // The last write is registered now; IDLE drops mem_we next.
                  r_state      <= IDLE;
                  r_clear_done <= 1'b1;
               end
            end

            IDLE: begin
               r_mem_we <= 1'b0;
               if (r_clear_pending || bus.clear_req) begin
                  // A clear outranks any waiting request.
                  r_clear_pending <= 1'b0;
                  r_clear_done    <= 1'b0;
                  r_state         <= CLEAR;
               end else if (w_valid) begin
                  r_mem_we     <= w_win_we;
                  r_mem_waddr  <= w_win_addr;
                  r_mem_wdata  <= w_win_wdata;
                  r_gnt        <= w_winner;
                  r_last_grant <= w_winner;
                  r_state      <= ISSUE;
               end
            end

            ISSUE: begin
               // The RAM commits the access at the end of this cycle.
               r_mem_we <= 1'b0;
               if (bus.clear_req) begin
                  r_clear_pending <= 1'b1;
                  r_clear_done    <= 1'b0;
               end
               r_state <= WAIT;
            end

            WAIT: begin
               // mem_doutb now holds the contents from before the access.
               if (bus.clear_req) begin
                  r_clear_pending <= 1'b1;
                  r_clear_done    <= 1'b0;
               end
               if (r_gnt == GNT_A) begin
                  r_a_ack   <= 1'b1;
                  r_a_rdata <= bus.mem_doutb;
               end else begin
                  r_b_ack   <= 1'b1;
                  r_b_rdata <= bus.mem_doutb;
               end
               r_state <= IDLE;
            end

            default: r_state <= CLEAR;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output drive
   // ---------------------------------------------------------------------------
   assign bus.clear_done = r_clear_done;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_waddr  = r_mem_waddr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.a_ack      = r_a_ack;
   assign bus.a_rdata    = r_a_rdata;
   assign bus.b_ack      = r_b_ack;
   assign bus.b_rdata    = r_b_rdata;

endmodule : dpram_port_sched

// File: tb/tb_dpram_port_sched.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_sched
// Directed bench for dpram_port_sched with AW=4, FILL=8'hA5. A behavioural
// RAM (registered read-before-write doutb) sits on the memory port. Expected
// read data is pushed to per-requester queues when a request is presented and
// popped by an ack monitor.
// -----------------------------------------------------------------------------
module tb_dpram_port_sched;
   import dpram_sched_pkg::*;

   localparam int            AW   = 4;
   localparam int            DW   = 8;
   localparam int            DEPTH = 1 << AW;
   localparam logic [DW-1:0] FILL = 8'hA5;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dpram_port_sched_if #(.AW(AW), .DW(DW)) bus ();

   dpram_port_sched #(.AW(AW), .DW(DW), .FILL(FILL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural RAM: registered doutb, read-before-write.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      bus.mem_doutb <= ram[bus.mem_waddr];
      if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Scoreboard state
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] a_q [$];
   logic [DW-1:0] b_q [$];
   logic          ord_q [$];
   bit            gap_en = 1'b0;
   int            last_ack_cyc = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic score(input logic id, input logic [DW-1:0] rd);
      logic [DW-1:0] exp;
      logic          exp_id;
      if (id == GNT_A) begin
         check("a_ack_expected", a_q.size() != 0, 1'b1);
         if (a_q.size() != 0) begin
            exp = a_q.pop_front();
            check("a_rdata", rd, exp);
         end
      end else begin
         check("b_ack_expected", b_q.size() != 0, 1'b1);
         if (b_q.size() != 0) begin
            exp = b_q.pop_front();
            check("b_rdata", rd, exp);
         end
      end
      if (gap_en) begin
         check("grant_order_pending", ord_q.size() != 0, 1'b1);
         if (ord_q.size() != 0) begin
            exp_id = ord_q.pop_front();
            check("grant_order", id, exp_id);
         end
         if (last_ack_cyc >= 0) check("ack_spacing", cyc - last_ack_cyc, 3);
         last_ack_cyc = cyc;
      end
   endtask

   // Ack monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (!reset && (bus.a_ack || bus.b_ack)) begin
         check("single_ack", bus.a_ack & bus.b_ack, 1'b0);
         if (bus.a_ack) score(GNT_A, bus.a_rdata);
         if (bus.b_ack) score(GNT_B, bus.b_rdata);
      end
   end

   // Present a request and record the expected pre-access contents.
   task automatic present(input logic id, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
      if (id == GNT_A) begin
         bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
         a_q.push_back(ref_mem[addr]);
      end else begin
         bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
         b_q.push_back(ref_mem[addr]);
      end
      if (we) ref_mem[addr] = wd;
   endtask

   function automatic logic ack_of(input logic id);
      return (id == GNT_A) ? bus.a_ack : bus.b_ack;
   endfunction

   // Single uncontended access starting at an IDLE negedge; checks latency.
   task automatic access(input logic id, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
      present(id, we, addr, wd);
      @(negedge clk);
      check("acc_we_t1", bus.mem_we, we);
      check("acc_addr_t1", bus.mem_waddr, addr);
      if (we) check("acc_wdata_t1", bus.mem_wdata, wd);
      @(negedge clk);
      check("acc_we_t2", bus.mem_we, 1'b0);
      check("acc_ack_t2", ack_of(id), 1'b0);
      @(negedge clk);
      check("acc_ack_t3", ack_of(id), 1'b1);
      if (id == GNT_A) bus.a_req = 1'b0; else bus.b_req = 1'b0;
      @(negedge clk);
      check("acc_ack_t4", ack_of(id), 1'b0);
      check("acc_we_t4", bus.mem_we, 1'b0);
   endtask

   // Follow a clear sweep: clear_done low before it, 2^AW back-to-back writes.
   // Returns at the negedge after the last write cycle.
   task automatic expect_clear();
      int n = 0;
      while (bus.mem_we !== 1'b1 && n < 8) begin
         check("clr_done_pre", bus.clear_done, 1'b0);
         @(negedge clk);
         n++;
      end
      check("clr_start", bus.mem_we, 1'b1);
      for (int k = 0; k < DEPTH; k++) begin
         check("clr_we", bus.mem_we, 1'b1);
         check("clr_addr", bus.mem_waddr, k);
         check("clr_data", bus.mem_wdata, FILL);
         check("clr_done", bus.clear_done, (k == DEPTH - 1));
         check("clr_noack", bus.a_ack | bus.b_ack, 1'b0);
         @(negedge clk);
      end
      check("clr_end_we", bus.mem_we, 1'b0);
      check("clr_end_done", bus.clear_done, 1'b1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
   endtask

   task automatic check_ram_filled();
      for (int i = 0; i < DEPTH; i++) check("ram_fill", ram[i], FILL);
   endtask

   task automatic wait_ack(output bit got, input int budget);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = bus.a_ack | bus.b_ack;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      int a_issued, b_issued, a_done, b_done;

      bus.clear_req = 1'b0;
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

      // Reset values
      #1;
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_waddr", bus.mem_waddr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_a_ack", bus.a_ack, 1'b0);
      check("rst_b_ack", bus.b_ack, 1'b0);
      check("rst_a_rdata", bus.a_rdata, 0);
      check("rst_b_rdata", bus.b_rdata, 0);
      check("rst_clear_done", bus.clear_done, 1'b0);

      // Power-up clear
      @(negedge clk);
      reset = 1'b0;
      expect_clear();
      check_ram_filled();

      // A write then read of addr 5, B read of addr 5
      access(GNT_A, 1'b1, 4'd5, 8'h3C);
      access(GNT_A, 1'b0, 4'd5, 8'h00);
      access(GNT_B, 1'b0, 4'd5, 8'h00);

      // Both requesters held: alternating grants, 3-cycle ack spacing
      for (int k = 0; k < 4; k++) begin
         ord_q.push_back(GNT_A);
         ord_q.push_back(GNT_B);
      end
      gap_en = 1'b1;
      last_ack_cyc = -1;
      present(GNT_A, 1'b1, 4'd1, 8'h10);
      present(GNT_B, 1'b1, 4'd9, 8'h90);
      a_issued = 1; b_issued = 1; a_done = 0; b_done = 0;
      while (a_done + b_done < 8) begin
         wait_ack(got, 12);
         check("arb_ack_timeout", got, 1'b1);
         if (!got) break;
         if (bus.a_ack) begin
            a_done++;
            if (a_issued < 4) begin
               present(GNT_A, (a_issued != 3), 4'(1 + (a_issued % 2)), 8'(8'h10 + a_issued));
               a_issued++;
            end else bus.a_req = 1'b0;
         end
         if (bus.b_ack) begin
            b_done++;
            if (b_issued < 4) begin
               present(GNT_B, 1'b1, 4'(9 + (b_issued % 2)), 8'(8'h90 + b_issued));
               b_issued++;
            end else bus.b_req = 1'b0;
         end
      end
      @(negedge clk);
      gap_en = 1'b0;
      check("arb_no_extra_ack", bus.a_ack | bus.b_ack, 1'b0);
      check("arb_order_drained", ord_q.size(), 0);
      check("arb_a_q_drained", a_q.size(), 0);
      check("arb_b_q_drained", b_q.size(), 0);
      check("ram_b_last", ram[10], 8'h93);

      // B held across a clear started by clear_req
      bus.clear_req = 1'b1;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd9; bus.b_wdata = 8'h00;
      @(negedge clk);
      bus.clear_req = 1'b0;
      check("clrq_done_low", bus.clear_done, 1'b0);
      expect_clear();
      b_q.push_back(ref_mem[9]);
      check("clrq_b_we_t1", bus.mem_we, 1'b0);
      check("clrq_b_addr_t1", bus.mem_waddr, 9);
      check("clrq_b_ack_t1", bus.b_ack, 1'b0);
      @(negedge clk);
      check("clrq_b_ack_t2", bus.b_ack, 1'b0);
      @(negedge clk);
      check("clrq_b_ack_t3", bus.b_ack, 1'b1);
      bus.b_req = 1'b0;
      @(negedge clk);
      check("clrq_b_ack_t4", bus.b_ack, 1'b0);
      check("clrq_b_q_drained", b_q.size(), 0);

      // clear_req during the ISSUE cycle of an A write
      present(GNT_A, 1'b1, 4'd3, 8'h5A);
      @(negedge clk);
      check("iss_clr_we", bus.mem_we, 1'b1);
      check("iss_clr_addr", bus.mem_waddr, 3);
      bus.clear_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      check("iss_clr_done_low", bus.clear_done, 1'b0);
      check("iss_clr_ack_wait", bus.a_ack, 1'b0);
      @(negedge clk);
      check("iss_clr_ack", bus.a_ack, 1'b1);
      check("iss_clr_done_low2", bus.clear_done, 1'b0);
      bus.a_req = 1'b0;
      expect_clear();
      check("iss_clr_a_q_drained", a_q.size(), 0);
      check("iss_clr_ram3", ram[3], FILL);

      // Reset mid-clear at cnt=7 (address 6 is on the port)
      bus.clear_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = bus.mem_we && (bus.mem_waddr == 4'd6);
      end
      check("mid_clr_reached", got, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_mem_we", bus.mem_we, 1'b0);
      check("mid_rst_mem_waddr", bus.mem_waddr, 0);
      check("mid_rst_mem_wdata", bus.mem_wdata, 0);
      check("mid_rst_clear_done", bus.clear_done, 1'b0);
      check("mid_rst_acks", bus.a_ack | bus.b_ack, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      expect_clear();
      check_ram_filled();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dpram_port_sched

// File: doc/dpram_port_sched.md
Name: dpram_port_sched

Overview:
- Sequences and shares the registered write/readback port (we, waddr, wdata, doutb) of a dual-port video/work RAM between two requesters: A (CPU side) and B (loader/debug side).
- After reset, and on demand, it fills the whole RAM with a fill value before granting any access.
- Sits between the requesters and the RAM; the RAM's read-only port stays with scan-out and is not touched.

Parameters:
- AW, 10, RAM address width; RAM depth is 2^AW.
- DW, 8, data width.
- FILL, 0, value written to every location during a clear.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  single-cycle pulse that requests a full-RAM clear.
- clear_done  out  1  high when no clear is running or pending.
- a_req  in  1  requester A access request (level).
- a_we  in  1  A write enable (0 = read).
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_ack  out  1  one-cycle completion pulse to A.
- a_rdata  out  DW  RAM contents at a_addr before the access; valid while a_ack=1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for requester B.
- mem_we  out  1  to the RAM we.
- mem_waddr  out  AW  to the RAM waddr.
- mem_wdata  out  DW  to the RAM wdata.
- mem_doutb  in  DW  from the RAM doutb (registered, one-cycle latency).

Behaviour:
- Reset values:
  - mem_we=0, mem_waddr=0, mem_wdata=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - clear_done=0, state=CLEAR, clear counter=0, last_grant=B, clear_pending=0.
- Reset asserted mid-operation aborts any access or clear immediately; after release a full clear restarts from address 0.
- States:
  - CLEAR: each cycle register mem_we=1, mem_waddr=cnt, mem_wdata=FILL, then cnt++.
    - After the write of address 2^AW-1, go to IDLE, set clear_done=1, and force mem_we=0.
    - Exactly 2^AW consecutive write cycles, no gaps. The counter wraps to 0 for the next clear.
  - IDLE:
    - If clear_pending or clear_req: clear_done=0, go to CLEAR.
    - Otherwise, if any req: pick the winner, register mem_waddr/mem_wdata/mem_we from the winner, latch the winner id, and go to ISSUE.
    - Otherwise hold mem_we=0.
  - ISSUE (one cycle): the RAM performs the access at the end of this cycle. Next cycle mem_we=0; go to WAIT.
  - WAIT (one cycle): mem_doutb is valid. Register it into the winner's rdata, pulse the winner's ack for one cycle, and go to IDLE.
- Timing:
  - With req sampled in IDLE at cycle T: mem_we is visible at T+1, and ack/rdata at T+3.
  - The ack cycle is itself an IDLE cycle, so maximum throughput is one access per 3 cycles.
- Requester rule:
  - req, we, addr and wdata must be held stable from assertion until ack.
  - A req still high in the ack cycle counts as a new request using the fields presented in that cycle.
- rdata is the pre-access contents (read-before-write). For a read, mem_we stays 0 throughout.
- Arbitration, when both request in IDLE:
  - The requester not equal to last_grant wins; last_grant updates on every grant.
  - With a single requester, it wins regardless of last_grant.
- Non-granted requesters wait; there is no timeout, and requests are never dropped.
- clear_req handling:
  - During ISSUE/WAIT: sets clear_pending and clears clear_done in the next cycle. The in-flight access completes and acks first, then CLEAR starts.
  - During CLEAR: ignored.
- Requests that arrive during CLEAR are held unacked until clear_done rises, then arbitrated normally.

Decomposition:
- Shared package dpram_sched_pkg:
  - state enum {CLEAR, IDLE, ISSUE, WAIT};
  - grant id constants GNT_A=0, GNT_B=1.
- One sub-module, dpram_rr_arb2: combinational 2-way round-robin pick from (a_req, b_req, last_grant), returning winner id and valid.
- The top level owns the FSM, clear counter, output registers and last_grant.

Test Plan:
- AW=4, FILL=8'hA5, reset released: 16 consecutive cycles with mem_we=1 and addresses 0..15 in order, then clear_done=1; every RAM location reads A5.
- A writes 8'h3C to addr 5 after the clear: mem_we is high for exactly 1 cycle at T+1 with waddr=5; a_ack at T+3 with a_rdata=A5. A then reads addr 5: a_rdata=3C, and mem_we never rises.
- a_req and b_req asserted together and held for 4 requests each: grants alternate A,B,A,B,...; every ack is 3 cycles apart; no ack is missed or duplicated.
- b_req held during a clear started by clear_req: no b_ack until clear_done=1; b_ack then arrives 3 cycles after the first IDLE cycle.
- clear_req pulsed in the ISSUE cycle of an A write: a_ack still arrives with correct rdata, then a 16-cycle clear runs; clear_done is low from the cycle after clear_req until the clear ends.
- reset pulsed mid-clear at cnt=7: outputs go to reset values immediately; after release the clear restarts at address 0 and runs the full 16 cycles.
